// File: rtl/fire_scheduler.sv
// rtl/fire_scheduler.sv - one-hot-in-time fire index scheduler; optional FIRE_SCHED_FAIRNESS_EN
module fire_scheduler #(
    parameter int N               = 16,
    parameter int FW              = $clog2(N + 1),
    parameter int MAX_WAIT        = 8,
    parameter int DEADLOCK_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  excited,
    input  logic [FW-1:0] choice,
    input  logic          hold,
    output logic [FW-1:0] fire,
    output logic          fire_valid,
    output logic          forced,
    output logic          deadlock,
    output logic [FW-1:0] rr_ptr
);

    localparam logic [FW-1:0] NONE  = FW'(N);
    localparam logic [FW-1:0] LAST  = FW'(N - 1);
    localparam int            QW    = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [QW-1:0] QLAST = QW'(DEADLOCK_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;

    if (N < 2 || MAX_WAIT < 1 || DEADLOCK_CYCLES < 2) begin : g_param_check
        $error("fire_scheduler: unsupported parameter set");
    end

    logic [1:0]      state;
    logic [QW-1:0]   quiet_cnt;
    logic            active;
    logic [N-1:0]    ex_choice;
    logic [2*N-1:0]  ex_rot;
    logic            choice_ok;
    logic            ptr_excited;
    logic            force_now;
    logic            rr_found;
    logic [FW-1:0]   rr_idx;
    logic [FW:0]     rr_sum;
    logic            advance;
    logic [FW-1:0]   ptr_next;

    assign active      = (state == S_RUN || state == S_QUIET) && !hold;
    assign ex_choice   = excited >> choice;
    assign choice_ok   = (choice < NONE) && ex_choice[0];
    // Doubled vector rotated by rr_ptr: bit i is excited[(rr_ptr+i) mod N]
    assign ex_rot      = {excited, excited} >> rr_ptr;
    assign ptr_excited = ex_rot[0];
    assign ptr_next    = (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;

`ifdef FIRE_SCHED_FAIRNESS_EN
    localparam int            WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    logic [WW-1:0] wait_cnt;

    assign force_now = ptr_excited && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (active) begin
            if (advance) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign force_now = 1'b0;
`endif

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = NONE;
        rr_sum   = '0;
        for (int i = 0; i < N; i++) begin
            if (!rr_found && ex_rot[i]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr} + (FW+1)'(i);
                if (rr_sum >= (FW+1)'(N)) begin
                    rr_sum = rr_sum - (FW+1)'(N);
                end
                rr_idx = rr_sum[FW-1:0];
            end
        end
    end

    always_comb begin
        fire   = NONE;
        forced = 1'b0;
        if (active) begin
            if (force_now) begin
                fire   = rr_ptr;
                forced = 1'b1;
            end else if (choice_ok) begin
                fire = choice;
            end else begin
                fire = rr_idx;
            end
        end
    end

    assign fire_valid = (fire != NONE);
    assign deadlock   = (state == S_DEAD);
    // Pointer moves on once its target fired or has nothing to fire
    assign advance    = active && ((fire == rr_ptr) || !ptr_excited);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            quiet_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    if (!hold && excited == '0) begin
                        state     <= S_QUIET;
                        quiet_cnt <= QW'(1);
                    end
                end
                S_QUIET: begin
                    if (!hold) begin
                        if (excited != '0) begin
                            state     <= S_RUN;
                            quiet_cnt <= '0;
                        end else if (quiet_cnt == QLAST) begin
                            state <= S_DEAD;
                        end else begin
                            quiet_cnt <= quiet_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_DEAD;
            endcase
            if (advance) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_fire_scheduler.sv
// tb/tb_fire_scheduler.sv - directed vector bench for fire_scheduler (N=4)
module tb_fire_scheduler;

    localparam int N  = 4;
    localparam int FW = $clog2(N + 1);
`ifdef FIRE_SCHED_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk;
    logic          clk_en;
    logic          rst_n;
    logic [N-1:0]  excited;
    logic [FW-1:0] choice;
    logic          hold;
    logic [FW-1:0] fire;
    logic          fire_valid;
    logic          forced;
    logic          deadlock;
    logic [FW-1:0] rr_ptr;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [N-1:0]  exc;
        logic [FW-1:0] ch;
        logic          hld;
        logic [FW-1:0] exp_fire;
        logic          exp_valid;
    } vec_t;

    vec_t vecs[12];

    fire_scheduler #(
        .N(N), .FW(FW), .MAX_WAIT(8), .DEADLOCK_CYCLES(4)
    ) dut (
        .clk(clk), .reset(rst_n), .excited(excited), .choice(choice), .hold(hold),
        .fire(fire), .fire_valid(fire_valid), .forced(forced), .deadlock(deadlock),
        .rr_ptr(rr_ptr)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0110, 3'd2, 1'b0, 3'd2, 1'b1};
        vecs[1]  = '{4'b0110, 3'd0, 1'b0, 3'd1, 1'b1};
        vecs[2]  = '{4'b0110, 3'd4, 1'b0, 3'd1, 1'b1};
        vecs[3]  = '{4'b0110, 3'd7, 1'b0, 3'd1, 1'b1};
        vecs[4]  = '{4'b1000, 3'd0, 1'b0, 3'd3, 1'b1};
        vecs[5]  = '{4'b1000, 3'd3, 1'b0, 3'd3, 1'b1};
        vecs[6]  = '{4'b0001, 3'd4, 1'b0, 3'd0, 1'b1};
        vecs[7]  = '{4'b0000, 3'd1, 1'b0, 3'd4, 1'b0};
        vecs[8]  = '{4'b1111, 3'd3, 1'b1, 3'd4, 1'b0};
        vecs[9]  = '{4'b1111, 3'd3, 1'b0, 3'd3, 1'b1};
        vecs[10] = '{4'b1111, 3'd5, 1'b0, 3'd0, 1'b1};
        vecs[11] = '{4'b1100, 3'd1, 1'b0, 3'd2, 1'b1};

        clk     = 1'b0;
        clk_en  = 1'b1;
        rst_n   = 1'b0;
        excited = 4'hF;
        choice  = 3'd4;
        hold    = 1'b0;

        // Reset held for three clocks, then one IDLE clock with no fire
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_fire", fire, N);
            check("reset_valid", fire_valid, 0);
            check("reset_forced", forced, 0);
            check("reset_deadlock", deadlock, 0);
            check("reset_rr_ptr", rr_ptr, 0);
        end
        rst_n = 1'b1;
        #1;
        check("idle_fire", fire, N);
        tick();
        check("first_grant_fire", fire, 0);
        check("first_grant_valid", fire_valid, 1);

        // Freeze the clock in RUN with rr_ptr=0 and sweep the grant logic
        clk_en = 1'b0;
        for (int v = 0; v < 12; v++) begin
            excited = vecs[v].exc;
            choice  = vecs[v].ch;
            hold    = vecs[v].hld;
            #1;
            check($sformatf("vec%0d_fire", v), fire, vecs[v].exp_fire);
            check($sformatf("vec%0d_valid", v), fire_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_forced", v), forced, 0);
            check($sformatf("vec%0d_rr_ptr", v), rr_ptr, 0);
        end

        // Mid-cycle reset drops fire at once
        hold    = 1'b0;
        excited = 4'b0011;
        choice  = 3'd1;
        #1;
        check("pre_reset_fire", fire, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_fire", fire, N);
        clk_en = 1'b1;

        // Fairness: choice pins index 1 while rr_ptr waits on index 0
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("fair%0d_fire", k), fire, (FAIR && k == 8) ? 0 : 1);
            check($sformatf("fair%0d_forced", k), forced, (FAIR && k == 8) ? 1 : 0);
            check($sformatf("fair%0d_rr_ptr", k), rr_ptr, 0);
        end
        tick();
        check("fair_after_rr_ptr", rr_ptr, FAIR ? 1 : 0);
        check("fair_after_fire", fire, 1);
        check("fair_after_forced", forced, 0);

        // Deadlock after four quiet edges, sticky until reset
        excited = 4'b0000;
        choice  = 3'd4;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("dead%0d_flag", e), deadlock, (e == 4) ? 1 : 0);
            check($sformatf("dead%0d_fire", e), fire, N);
        end
        excited = 4'b0001;
        tick();
        check("dead_sticky_flag", deadlock, 1);
        check("dead_sticky_fire", fire, N);
        check("dead_sticky_valid", fire_valid, 0);
        rst_n = 1'b0;
        #1;
        check("dead_reset_flag", deadlock, 0);

        // Hold freezes grants and pointer
        excited = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        hold = 1'b1;
        #1;
        check("hold_fire", fire, N);
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("hold%0d_fire", h), fire, N);
            check($sformatf("hold%0d_rr_ptr", h), rr_ptr, 0);
        end
        hold = 1'b0;
        #1;
        check("unhold_fire", fire, 3);
        for (int p = 1; p <= 4; p++) begin
            tick();
            check($sformatf("walk%0d_rr_ptr", p), rr_ptr, p % N);
            check($sformatf("walk%0d_fire", p), fire, 3);
        end

        // Hold also freezes the quiet counter
        hold    = 1'b1;
        excited = 4'b0000;
        for (int h = 0; h < 5; h++) begin
            tick();
            check($sformatf("hq%0d_deadlock", h), deadlock, 0);
        end
        hold = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("hqd%0d_deadlock", e), deadlock, (e == 4) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
